// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback
// Purpose  : Register-file write master. Merges ALU and queued MDU/load
//            writebacks into one registered write port. Tracks pending MDU
//            writes so decode can stall on RAW hazards.
// Options  : WB_BYPASS_EN adds forwarding of the in-flight write.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        AluValid,
    input  logic [4:0]  AluRdAddr,
    input  logic [31:0] AluData,
    input  logic        MduValid,
    output logic        MduReady,
    input  logic [4:0]  MduRdAddr,
    input  logic [31:0] MduData,
    input  logic [4:0]  RsAddr,
    input  logic [4:0]  RtAddr,
    output logic        RsBusy,
    output logic        RtBusy,
    output logic        RegWrite,
    output logic [4:0]  RdAddr,
    output logic [31:0] RdData
`ifdef WB_BYPASS_EN
    ,
    output logic        RsFwd,
    output logic        RtFwd,
    output logic [31:0] RsFwdData,
    output logic [31:0] RtFwdData
`endif
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_stale;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_alu_req;
    logic [c_AW-1:0]  w_widx;
    logic [c_AW-1:0]  w_ridx;
    logic             w_rs_hit;
    logic             w_rt_hit;

    assign w_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_widx    = r_wptr[c_AW-1:0];
    assign w_ridx    = r_rptr[c_AW-1:0];
    assign MduReady  = !w_full;

    // Writes to r0 complete the handshake but are dropped on the floor.
    assign w_push    = MduValid && !w_full && (MduRdAddr != 5'd0);
    assign w_alu_req = AluValid && (AluRdAddr != 5'd0);
    assign w_pop     = !w_alu_req && !w_empty;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_valid <= '0;
            r_stale <= '0;
        end else begin
            // ALU overwrite squashes older queued writes to the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_req && r_valid[i] && (r_addr[i] == AluRdAddr))
                    r_stale[i] <= 1'b1;
            end
            if (w_push) begin
                r_valid[w_widx] <= 1'b1;
                r_stale[w_widx] <= 1'b0;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[w_ridx] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_addr[w_widx] <= MduRdAddr;
            r_data[w_widx] <= MduData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            RegWrite <= 1'b0;
            RdAddr   <= 5'd0;
            RdData   <= 32'd0;
        end else if (w_alu_req) begin
            RegWrite <= 1'b1;
            RdAddr   <= AluRdAddr;
            RdData   <= AluData;
        end else if (!w_empty) begin
            RegWrite <= !r_stale[w_ridx];
            RdAddr   <= r_addr[w_ridx];
            RdData   <= r_data[w_ridx];
        end else begin
            RegWrite <= 1'b0;
        end
    end

    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_stale[i] && (r_addr[i] == RsAddr))
                w_rs_hit = 1'b1;
            if (r_valid[i] && !r_stale[i] && (r_addr[i] == RtAddr))
                w_rt_hit = 1'b1;
        end
    end

    assign RsBusy = w_rs_hit && (RsAddr != 5'd0);
    assign RtBusy = w_rt_hit && (RtAddr != 5'd0);

`ifdef WB_BYPASS_EN
    assign RsFwd     = RegWrite && (RdAddr == RsAddr) && (RsAddr != 5'd0);
    assign RtFwd     = RegWrite && (RdAddr == RtAddr) && (RtAddr != 5'd0);
    assign RsFwdData = RdData;
    assign RtFwdData = RdData;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback
// Purpose  : Directed scenarios plus random traffic for reg_writeback, checked
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        AluValid;
    logic [4:0]  AluRdAddr;
    logic [31:0] AluData;
    logic        MduValid;
    logic        MduReady;
    logic [4:0]  MduRdAddr;
    logic [31:0] MduData;
    logic [4:0]  RsAddr;
    logic [4:0]  RtAddr;
    logic        RsBusy;
    logic        RtBusy;
    logic        RegWrite;
    logic [4:0]  RdAddr;
    logic [31:0] RdData;
`ifdef WB_BYPASS_EN
    logic        RsFwd;
    logic        RtFwd;
    logic [31:0] RsFwdData;
    logic [31:0] RtFwdData;
`endif

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .AluValid  (AluValid),
        .AluRdAddr (AluRdAddr),
        .AluData   (AluData),
        .MduValid  (MduValid),
        .MduReady  (MduReady),
        .MduRdAddr (MduRdAddr),
        .MduData   (MduData),
        .RsAddr    (RsAddr),
        .RtAddr    (RtAddr),
        .RsBusy    (RsBusy),
        .RtBusy    (RtBusy),
        .RegWrite  (RegWrite),
        .RdAddr    (RdAddr),
        .RdData    (RdData)
`ifdef WB_BYPASS_EN
        ,
        .RsFwd     (RsFwd),
        .RtFwd     (RtFwd),
        .RsFwdData (RsFwdData),
        .RtFwdData (RtFwdData)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          stale;
    } ent_t;

    ent_t        m_q[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] a);
        bit hit = 1'b0;
        foreach (m_q[i]) if (!m_q[i].stale && m_q[i].addr == a) hit = 1'b1;
        return hit && (a != 5'd0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_we   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
    endtask

    task automatic compare_all();
        check("regwrite", RegWrite, m_we);
        check("rdaddr", RdAddr, m_addr);
        check("rddata", RdData, m_data);
        check("mduready", MduReady, m_q.size() < DEPTH);
        check("rsbusy", RsBusy, m_busy(RsAddr));
        check("rtbusy", RtBusy, m_busy(RtAddr));
`ifdef WB_BYPASS_EN
        check("rsfwd", RsFwd, m_we && m_addr == RsAddr && RsAddr != 5'd0);
        check("rtfwd", RtFwd, m_we && m_addr == RtAddr && RtAddr != 5'd0);
        check("rsfwddata", RsFwdData, m_data);
        check("rtfwddata", RtFwdData, m_data);
`endif
    endtask

    // Reference: priority ALU > queue head; enqueue happens after the squash.
    task automatic model_edge(output bit acc);
        ent_t e;
        acc = MduValid && (m_q.size() < DEPTH);
        if (AluValid && AluRdAddr != 5'd0) begin
            m_we   = 1'b1;
            m_addr = AluRdAddr;
            m_data = AluData;
            foreach (m_q[i]) if (m_q[i].addr == AluRdAddr) m_q[i].stale = 1'b1;
        end else if (m_q.size() > 0) begin
            e      = m_q.pop_front();
            m_we   = !e.stale;
            m_addr = e.addr;
            m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (acc && MduRdAddr != 5'd0) m_q.push_back('{MduRdAddr, MduData, 1'b0});
    endtask

    task automatic cycle(output bit acc);
        @(negedge Clock);
        compare_all();
        model_edge(acc);
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        AluValid  = 1'b0;
        AluRdAddr = 5'd0;
        AluData   = 32'd0;
        MduValid  = 1'b0;
        MduRdAddr = 5'd0;
        MduData   = 32'd0;
    endtask

    initial begin
        bit          acc;
        int          next_addr;
        logic [4:0]  got[$];
        logic [4:0]  exp_seq[5];
        logic [31:0] rnd;

        Reset  = 1'b1;
        RsAddr = 5'd0;
        RtAddr = 5'd0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        check("rst_regwrite", RegWrite, 0);
        check("rst_rdaddr", RdAddr, 0);
        check("rst_rddata", RdData, 0);
        check("rst_ready", MduReady, 1);
        Reset = 1'b0;

        // ALU single write
        AluValid = 1'b1; AluRdAddr = 5'd5; AluData = 32'hDEADBEEF;
        cycle(acc);
        idle_inputs();
        check("alu_we", RegWrite, 1);
        check("alu_addr", RdAddr, 5);
        check("alu_data", RdData, 32'hDEADBEEF);
        cycle(acc);
        check("alu_we_drop", RegWrite, 0);

        // MDU single write with RAW lookup
        RsAddr = 5'd7;
        MduValid = 1'b1; MduRdAddr = 5'd7; MduData = 32'h12345678;
        cycle(acc);
        idle_inputs();
        check("mdu_acc", acc, 1);
        check("mdu_busy_rise", RsBusy, 1);
        cycle(acc);
        check("mdu_we", RegWrite, 1);
        check("mdu_addr", RdAddr, 7);
        check("mdu_busy_fall", RsBusy, 0);

        // Fill the FIFO behind continuous ALU traffic
        AluValid = 1'b1; AluRdAddr = 5'd1; AluData = 32'h1;
        next_addr = 2;
        for (int c = 0; c < 6; c++) begin
            MduValid  = (next_addr <= 6);
            MduRdAddr = 5'(next_addr);
            MduData   = 32'(next_addr * 16);
            cycle(acc);
            if (acc) next_addr++;
        end
        check("fill_ready", MduReady, 0);
        AluValid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            MduValid  = (next_addr <= 6);
            MduRdAddr = 5'(next_addr);
            MduData   = 32'(next_addr * 16);
            cycle(acc);
            if (acc) next_addr++;
            if (RegWrite) got.push_back(RdAddr);
        end
        idle_inputs();
        exp_seq = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        check("order_len", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("order_addr", got[i], exp_seq[i]);

        // WAW squash
        RtAddr = 5'd9;
        MduValid = 1'b1; MduRdAddr = 5'd9; MduData = 32'd1;
        cycle(acc);
        idle_inputs();
        check("squash_busy_pre", RtBusy, 1);
        AluValid = 1'b1; AluRdAddr = 5'd9; AluData = 32'd2;
        cycle(acc);
        idle_inputs();
        check("squash_alu_we", RegWrite, 1);
        check("squash_alu_data", RdData, 2);
        check("squash_busy", RtBusy, 0);
        cycle(acc);
        check("squash_stale_we", RegWrite, 0);
        check("squash_stale_addr", RdAddr, 9);

        // Asynchronous reset with entries queued
        RsAddr = 5'd10;
        AluValid = 1'b1; AluRdAddr = 5'd1; AluData = 32'hF;
        next_addr = 10;
        for (int c = 0; c < 3; c++) begin
            MduValid  = 1'b1;
            MduRdAddr = 5'(next_addr);
            MduData   = 32'(next_addr);
            cycle(acc);
            if (acc) next_addr++;
        end
        idle_inputs();
        #2 Reset = 1'b1;
        #1;
        check("arst_we", RegWrite, 0);
        check("arst_addr", RdAddr, 0);
        check("arst_data", RdData, 0);
        check("arst_ready", MduReady, 1);
        check("arst_busy", RsBusy, 0);
        model_reset();
        #1 Reset = 1'b0;
        repeat (3) cycle(acc);

`ifdef WB_BYPASS_EN
        RsAddr = 5'd3;
        AluValid = 1'b1; AluRdAddr = 5'd3; AluData = 32'hA5A5A5A5;
        cycle(acc);
        idle_inputs();
        check("fwd_hit", RsFwd, 1);
        check("fwd_data", RsFwdData, 32'hA5A5A5A5);
        RsAddr = 5'd0;
        #1;
        check("fwd_r0", RsFwd, 0);
        cycle(acc);
`endif

        // Random traffic; MDU offer held until it transfers
        MduValid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rnd       = $urandom;
            AluValid  = (rnd[1:0] == 2'd0);
            AluRdAddr = 5'($urandom_range(0, 7));
            AluData   = $urandom;
            RsAddr    = 5'($urandom_range(0, 7));
            RtAddr    = 5'($urandom_range(0, 7));
            if (!MduValid && rnd[3:2] != 2'd0) begin
                MduValid  = 1'b1;
                MduRdAddr = 5'($urandom_range(0, 7));
                MduData   = $urandom;
            end
            cycle(acc);
            if (acc) MduValid = 1'b0;
        end
        idle_inputs();
        repeat (DEPTH + 2) cycle(acc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
